// File: rtl/irq_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
//   Shared types and constants for the interrupt controller.
//   - state_t    : handshake FSM states (IDLE, REQ, ACK, HOLD)
//   - REG_*      : register word offsets from the controller base address
//   - DEFAULT_VECTOR_BASE : vector offset added to the winning IRQ index
// ----------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_ISR  = 2'd2;
    localparam logic [1:0] REG_EOI  = 2'd3;

    localparam logic [15:0] DEFAULT_VECTOR_BASE = 16'h0000;

endpackage

// File: rtl/irq_priority_encoder.sv
// ----------------------------------------------------------------------------
// irq_priority_encoder
//   Combinational find-first-set: reports the lowest set index (index 0 is the
//   highest priority) plus a valid flag.
//   Ports:
//     req_i   [N-1:0]     request vector
//     valid_o             at least one bit of req_i is set
//     idx_o   [IDX_W-1:0] lowest set index (0 when nothing is set)
// ----------------------------------------------------------------------------
module irq_priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan from the lowest priority upward so the last hit is the winner.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// ----------------------------------------------------------------------------
// interrupt_controller
//   Programmable fixed-priority interrupt controller with edge-latched pending
//   bits, software mask, in-service nesting and an INT/INTACK handshake.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     irq_in   [NUM_IRQ-1:0]   request lines (rising edge sets pending)
//     irq_ack  [NUM_IRQ-1:0]   one-cycle one-hot pulse to the served source
//     int_out                  interrupt request to CPU (registered)
//     intack                   CPU acknowledge level
//     vector_out [DATA_W-1:0]  vector presented during ACK/HOLD
//     address, memwt, data_wr  CPU register write port
//     data_rd  [DATA_W-1:0]    combinational register read data
//     reg_hit                  address decodes to one of the 4 registers
// ----------------------------------------------------------------------------
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int                   NUM_IRQ     = 8,
    parameter int                   ADDR_W      = 12,
    parameter int                   DATA_W      = 16,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = 12'h230,
    parameter logic [DATA_W-1:0]    VECTOR_BASE = DEFAULT_VECTOR_BASE,
    parameter logic [NUM_IRQ-1:0]   RESET_MASK  = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_in,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic                int_out,
    input  logic                intack,
    output logic [DATA_W-1:0]   vector_out,
    input  logic [ADDR_W-1:0]   address,
    input  logic                memwt,
    input  logic [DATA_W-1:0]   data_wr,
    output logic [DATA_W-1:0]   data_rd,
    output logic                reg_hit
);

    localparam int IDX_W = $clog2(NUM_IRQ + 1);

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   irq_prev_q;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   isr_q, isr_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d;
    logic [NUM_IRQ-1:0]   irq_ack_q, irq_ack_d;
    logic [DATA_W-1:0]    vector_q, vector_d;
    logic                 int_out_q;

    logic [NUM_IRQ-1:0]   rise, above, eligible, serve_mask, eoi_mask;
    logic                 win_valid, isr_valid, serve;
    logic [IDX_W-1:0]     win_idx, isr_idx;
    logic [ADDR_W-1:0]    addr_off;
    logic [1:0]           reg_off;
    logic                 reg_wr;
    logic                 unused_data_wr;

    // ---------------- address decode ----------------
    assign addr_off = address - BASE_ADDR;
    assign reg_hit  = (addr_off < ADDR_W'(4));
    assign reg_off  = addr_off[1:0];
    assign reg_wr   = memwt & reg_hit;
    assign unused_data_wr = ^data_wr;

    // ---------------- priority resolution ----------------
    assign rise = irq_in & ~irq_prev_q;

    irq_priority_encoder #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_isr_enc (
        .req_i   (isr_q),
        .valid_o (isr_valid),
        .idx_o   (isr_idx)
    );

    // Only levels strictly more urgent than the current in-service level nest.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_above
        assign above[gi] = ~isr_valid | (IDX_W'(gi) < isr_idx);
    end

    assign eligible = pending_q & ~mask_q & above;

    irq_priority_encoder #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_win_enc (
        .req_i   (eligible),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (intack)         state_d = ACK;   // spurious acknowledge
                else if (win_valid) state_d = REQ;
            end
            REQ: begin
                if (intack)          state_d = ACK;
                else if (!win_valid) state_d = IDLE;
            end
            ACK:  state_d = HOLD;
            HOLD: if (!intack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath next values ----------------
    always_comb begin
        serve      = (state_q == REQ) && intack && win_valid;
        serve_mask = serve ? (NUM_IRQ'(1) << win_idx) : '0;
        irq_ack_d  = serve_mask;
        vector_d   = vector_q;
        if ((state_q == IDLE || state_q == REQ) && intack) begin
            // No eligible winner at acknowledge time yields the spurious vector.
            vector_d = serve ? (VECTOR_BASE + DATA_W'(win_idx))
                             : (VECTOR_BASE + DATA_W'(NUM_IRQ));
        end else if (state_q == HOLD && !intack) begin
            vector_d = '0;
        end
    end

    // ---------------- register file next values ----------------
    always_comb begin
        eoi_mask  = (reg_wr && reg_off == REG_EOI) ? data_wr[NUM_IRQ-1:0] : '0;
        mask_d    = (reg_wr && reg_off == REG_MASK) ? data_wr[NUM_IRQ-1:0] : mask_q;
        // A fresh edge on the served bit is a new event, so rise wins.
        pending_d = (pending_q & ~serve_mask) | rise;
        // Acknowledge setting a bit wins over a simultaneous EOI clearing it.
        isr_d     = (isr_q & ~eoi_mask) | serve_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            isr_q      <= '0;
            mask_q     <= RESET_MASK;
            irq_ack_q  <= '0;
            vector_q   <= '0;
            int_out_q  <= 1'b0;
        end else begin
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
            isr_q      <= isr_d;
            mask_q     <= mask_d;
            irq_ack_q  <= irq_ack_d;
            vector_q   <= vector_d;
            int_out_q  <= (state_d == REQ);
        end
    end

    assign int_out    = int_out_q;
    assign irq_ack    = irq_ack_q;
    assign vector_out = vector_q;

    // ---------------- register read ----------------
    always_comb begin
        data_rd = '0;
        if (reg_hit) begin
            case (reg_off)
                REG_MASK: data_rd = DATA_W'(mask_q);
                REG_PEND: data_rd = DATA_W'(pending_q);
                REG_ISR:  data_rd = DATA_W'(isr_q);
                default:  data_rd = '0;
            endcase
        end
    end

endmodule
